mcycle_unit: RTL and testbench
==============================

// Module: mcycle_unit
// PURPOSE
//   Multi-cycle multiply/divide unit and its sequencing controller for the single-cycle core.
//   Accepts one MUL/DIV request from decode and runs an iterative shift-add or restoring-divide loop.
//   Drives Busy, which stalls the program counter and holds the instruction in decode until results are valid.
// PARAMETERS
//   WIDTH    32   operand/result width; iteration count = WIDTH
// PORTS
//   CLK       in   1      clock, rising edge
//   Reset     in   1      synchronous, active-high
//   Start     in   1      request from decode; held high while the instruction is stalled
//   MCycleOp  in   1      0 = multiply, 1 = divide
//   Signed    in   1      1 = two's-complement operands, 0 = unsigned
//   Operand1  in   WIDTH  multiplicand / dividend
//   Operand2  in   WIDTH  multiplier / divisor
//   Result1   out  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
//   Result2   out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
//   Busy      out  1      high = stall PC; combinational
// BEHAVIOUR
//   - Reset: state IDLE, iteration counter 0, Result1/Result2 = 0, all internal regs 0.
//     Busy is forced to 0 in any cycle where Reset is high. Reset mid-operation aborts the operation.
//   - FSM states: IDLE, COMPUTING, DONE.
//   - IDLE:
//     - Busy = Start.
//     - On Start: latch op, Signed, |Operand1|, |Operand2| (|x| applied only when Signed=1).
//       Also latch the result-sign flags and the divide-by-zero flag (Operand2==0 with MCycleOp=1). Go to COMPUTING.
//   - COMPUTING:
//     - Busy = 1. Performs one iteration per cycle; the counter runs 0..WIDTH-1.
//     - Inputs are ignored. After iteration WIDTH-1, write sign-corrected results to Result1/Result2 and go to DONE.
//   - DONE:
//     - Busy = 0 and results are valid; the stalled instruction retires this cycle.
//     - Start is ignored (it belongs to the retiring instruction). Go unconditionally to IDLE.
//   - Latency: Busy is high for exactly WIDTH+1 consecutive cycles per request, then low for at least one cycle (DONE).
//     Back-to-back requests: Start seen in the IDLE cycle after DONE begins a new operation.
//   - Result1/Result2 are held from DONE until the next DONE or Reset. They do not change while COMPUTING.
//   - Multiply: unsigned shift-add over a 2*WIDTH accumulator.
//     Signed: negate the 2*WIDTH product if sign(Op1)^sign(Op2).
//   - Divide: restoring, one quotient bit per cycle.
//     Signed: quotient negated if sign(Op1)^sign(Op2); remainder takes the sign of the dividend (truncating division).
//   - Signed -2^(WIDTH-1) / -1: Result1 = 2^(WIDTH-1) bit pattern, Result2 = 0. No trap.
//   - Divide by zero, signed or unsigned: Result1 = all ones, Result2 = Operand1 as latched.
//     Full WIDTH+1 latency is still taken.
//   - Operand |x| uses WIDTH-bit unsigned arithmetic; the most-negative value maps to 2^(WIDTH-1) unsigned.
// STRUCTURE
//   - Package mcycle_pkg: state encoding (IDLE/COMPUTING/DONE), MCYCLE_MUL=1'b0, MCYCLE_DIV=1'b1.
//   - Sub-module mcycle_step: combinational single iteration.
//     MUL: conditional add plus shift. DIV: trial subtract, restore, quotient bit.
//     The top level holds the FSM, counter, operand/accumulator registers and sign correction.
// TESTING (WIDTH=32)
//   1. Unsigned MUL 0xFFFFFFFF*0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001.
//      Busy high exactly 33 cycles from the Start cycle.
//   2. Signed MUL -3*7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF.
//      Signed MUL 0x80000000*0x80000000 -> Result2=0x40000000, Result1=0.
//   3. Unsigned DIV 100/7 -> Result1=14, Result2=2. Signed DIV -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
//      Signed 0x80000000/-1 -> Result1=0x80000000, Result2=0.
//   4. DIV 5/0 (both Signed values) -> Result1=0xFFFFFFFF, Result2=5 after 33 Busy cycles.
//   5. Start held high through DONE -> no restart, Busy low for one cycle.
//      Start still high in the following IDLE cycle -> new 33-cycle operation.
//      Operands changed mid-COMPUTING -> results unaffected.
//   6. Reset asserted in COMPUTING cycle 10 -> Busy 0 that cycle.
//      Next cycle: IDLE, Result1=Result2=0. Fresh Start then completes correctly.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mcycle_pkg;

   typedef logic [1:0] mcycle_state_t;

   localparam mcycle_state_t IDLE      = 2'd0;
   localparam mcycle_state_t COMPUTING = 2'd1;
   localparam mcycle_state_t DONE      = 2'd2;

   localparam logic MCYCLE_MUL = 1'b0;
   localparam logic MCYCLE_DIV = 1'b1;

endpackage

// File: rtl/mcycle_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
module mcycle_step
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             op,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      trial   = shifted - {1'b0, operand};
      next_hi = '0;
      next_lo = '0;
      if (op == MCYCLE_MUL) begin
         // acc_lo starts as the multiplier and fills with product bits from the top
         next_hi = sum[WIDTH:1];
         next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end else if (trial[WIDTH]) begin
         next_hi = shifted[WIDTH-1:0];
         next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
         next_hi = trial[WIDTH-1:0];
         next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle MUL/DIV unit: FSM, operand/accumulator registers and sign correction.
module mcycle_unit
   import mcycle_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic             MCycleOp,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   mcycle_state_t    state;
   logic [CNT_W-1:0] count;
   logic             op;
   logic             is_signed;
   logic             sign1;
   logic             sign2;
   logic             div_zero;
   logic [WIDTH-1:0] dividend_raw;
   logic [WIDTH-1:0] operand_abs;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic signed [WIDTH-1:0] op1_s;
   logic signed [WIDTH-1:0] op2_s;
   logic             neg1_in;
   logic             neg2_in;
   logic [WIDTH-1:0] abs1_in;
   logic [WIDTH-1:0] abs2_in;

   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic [WIDTH-1:0]   fin1;
   logic [WIDTH-1:0]   fin2;
   logic               res_neg;
   logic               rem_neg;

   // WIDTH-bit two's-complement negate; the most-negative value maps onto itself
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   always_comb begin
      op1_s   = Operand1;
      op2_s   = Operand2;
      neg1_in = Signed && (op1_s < 0);
      neg2_in = Signed && (op2_s < 0);
      abs1_in = abs_val(Operand1, neg1_in);
      abs2_in = abs_val(Operand2, neg2_in);
   end

   mcycle_step #(.WIDTH(WIDTH)) u_step (
      .op      (op),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand_abs),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // Sign correction applied to the state after the final iteration
   always_comb begin
      res_neg   = is_signed && (sign1 ^ sign2);
      rem_neg   = is_signed && sign1;
      product   = neg_wide({step_hi, step_lo}, res_neg);
      quotient  = abs_val(step_lo, res_neg);
      remainder = abs_val(step_hi, rem_neg);
      if (div_zero) begin
         quotient  = '1;
         remainder = dividend_raw;
      end
      if (op == MCYCLE_MUL) begin
         fin1 = product[WIDTH-1:0];
         fin2 = product[2*WIDTH-1:WIDTH];
      end else begin
         fin1 = quotient;
         fin2 = remainder;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state        <= IDLE;
         count        <= '0;
         op           <= MCYCLE_MUL;
         is_signed    <= 1'b0;
         sign1        <= 1'b0;
         sign2        <= 1'b0;
         div_zero     <= 1'b0;
         dividend_raw <= '0;
         operand_abs  <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         Result1      <= '0;
         Result2      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  op           <= MCycleOp;
                  is_signed    <= Signed;
                  sign1        <= neg1_in;
                  sign2        <= neg2_in;
                  div_zero     <= (MCycleOp == MCYCLE_DIV) && (Operand2 == '0);
                  dividend_raw <= Operand1;
                  count        <= '0;
                  acc_hi       <= '0;
                  if (MCycleOp == MCYCLE_MUL) begin
                     operand_abs <= abs1_in;
                     acc_lo      <= abs2_in;
                  end else begin
                     operand_abs <= abs2_in;
                     acc_lo      <= abs1_in;
                  end
                  state <= COMPUTING;
               end
            end
            COMPUTING: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  Result1 <= fin1;
                  Result2 <= fin2;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      Busy = 1'b0;
      if (!Reset) begin
         case (state)
            IDLE:      Busy = Start;
            COMPUTING: Busy = 1'b1;
            default:   Busy = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit against an arithmetic reference model.
module tb_mcycle_unit;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic        MCycleOp = 1'b0;
   logic        Signed = 1'b0;
   logic [31:0] Operand1 = '0;
   logic [31:0] Operand2 = '0;
   logic [31:0] Result1;
   logic [31:0] Result2;
   logic        Busy;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        op;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   mcycle_unit #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .Start    (Start),
      .MCycleOp (MCycleOp),
      .Signed   (Signed),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy)
   );

   always #5 CLK = ~CLK;

   function automatic void model(input logic op, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r1, output logic [31:0] r2);
      longint      sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 1'b0) begin
         if (sgn) begin
            p  = sa * sb;
            r1 = p[31:0];
            r2 = p[63:32];
         end else begin
            up = {32'b0, a} * {32'b0, b};
            r1 = up[31:0];
            r2 = up[63:32];
         end
      end else if (b == 32'd0) begin
         r1 = 32'hFFFF_FFFF;
         r2 = a;
      end else if (sgn) begin
         q  = sa / sb;
         r  = sa % sb;
         r1 = q[31:0];
         r2 = r[31:0];
      end else begin
         r1 = a / b;
         r2 = a % b;
      end
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 300)) - 32'd150;
         default: return $urandom;
      endcase
   endfunction

   // Issues one request and returns results seen in the DONE cycle plus the Busy run length.
   task automatic do_op(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit hold,
                        output logic [31:0] r1, output logic [31:0] r2, output int busy_cyc);
      @(negedge CLK);
      Start = 1'b1; MCycleOp = op; Signed = sgn; Operand1 = a; Operand2 = b;
      #1 busy_cyc = Busy ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!Busy) break;
         busy_cyc++;
         if (scramble) begin
            Operand1 = $urandom; Operand2 = $urandom;
            MCycleOp = 1'($urandom); Signed = 1'($urandom);
         end
      end
      r1 = Result1;
      r2 = Result2;
      if (!hold) Start = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1; Start = 1'b1;
      repeat (3) @(negedge CLK);
      #1 vectors++;
      if (Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: Busy=%b expected 0", Busy);
      end
      @(negedge CLK);
      Reset = 1'b0; Start = 1'b0;
      #1 vectors++;
      if (Busy !== 1'b0 || Result1 !== 32'd0 || Result2 !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: Busy=%b R1=%h R2=%h expected 0/0/0", Busy, Result1, Result2);
      end
   endtask

   task automatic run_table(input string name, input vec_t tbl[$]);
      logic [31:0] r1, r2;
      int bc;
      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, 1'b0, 1'b0, r1, r2, bc);
         vectors++;
         if (r1 !== tbl[i].e1 || r2 !== tbl[i].e2) begin
            miscompares++;
            $display("FAIL %s[%0d]: R1=%h R2=%h expected %h %h", name, i, r1, r2, tbl[i].e1, tbl[i].e2);
         end
         vectors++;
         if (bc !== 33) begin
            miscompares++;
            $display("FAIL %s[%0d]_busy_cycles: got %0d expected 33", name, i, bc);
         end
      end
   endtask

   task automatic test_mul_directed;
      vec_t tbl[$];
      tbl.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE});
      tbl.push_back('{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000});
      run_table("mul", tbl);
   endtask

   task automatic test_div_directed;
      vec_t tbl[$];
      tbl.push_back('{1'b1, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2});
      tbl.push_back('{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF});
      tbl.push_back('{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
      tbl.push_back('{1'b1, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5});
      tbl.push_back('{1'b1, 1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5});
      run_table("div", tbl);
   endtask

   task automatic test_random(input int n, input bit scramble);
      logic [31:0] a, b, r1, r2, e1, e2;
      logic op, sgn;
      int bc;
      for (int i = 0; i < n; i++) begin
         op = 1'($urandom); sgn = 1'($urandom);
         a = pick_operand(); b = pick_operand();
         model(op, sgn, a, b, e1, e2);
         do_op(op, sgn, a, b, scramble, 1'b0, r1, r2, bc);
         vectors++;
         if (r1 !== e1 || r2 !== e2 || bc !== 33) begin
            miscompares++;
            $display("FAIL random%s op=%b sgn=%b a=%h b=%h: R1=%h R2=%h busy=%0d expected %h %h 33",
                     scramble ? "_scramble" : "", op, sgn, a, b, r1, r2, bc, e1, e2);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b, r1, r2, e1, e2;
      logic op, sgn;
      int bc;
      op = 1'($urandom); sgn = 1'($urandom);
      a = $urandom; b = $urandom_range(1, 1000);
      model(op, sgn, a, b, e1, e2);
      do_op(op, sgn, a, b, 1'b0, 1'b1, r1, r2, bc);
      vectors++;
      if (r1 !== e1 || r2 !== e2 || bc !== 33) begin
         miscompares++;
         $display("FAIL b2b_first: R1=%h R2=%h busy=%0d expected %h %h 33", r1, r2, bc, e1, e2);
      end
      @(negedge CLK);
      vectors++;
      if (Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_restart_busy: Busy=%b expected 1", Busy);
      end
      bc = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!Busy) break;
         bc++;
      end
      vectors++;
      if (Result1 !== e1 || Result2 !== e2 || bc !== 33) begin
         miscompares++;
         $display("FAIL b2b_second: R1=%h R2=%h busy=%0d expected %h %h 33", Result1, Result2, bc, e1, e2);
      end
      Start = 1'b0;
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] r1, r2, e1, e2;
      int bc;
      @(negedge CLK);
      Start = 1'b1; MCycleOp = 1'b0; Signed = 1'b0;
      Operand1 = $urandom; Operand2 = $urandom;
      repeat (11) @(negedge CLK);
      Reset = 1'b1;
      #1 vectors++;
      if (Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_busy: Busy=%b expected 0", Busy);
      end
      @(negedge CLK);
      Reset = 1'b0; Start = 1'b0;
      #1 vectors++;
      if (Busy !== 1'b0 || Result1 !== 32'd0 || Result2 !== 32'd0) begin
         miscompares++;
         $display("FAIL midreset_state: Busy=%b R1=%h R2=%h expected 0/0/0", Busy, Result1, Result2);
      end
      model(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, e1, e2);
      do_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, r1, r2, bc);
      vectors++;
      if (r1 !== e1 || r2 !== e2 || bc !== 33) begin
         miscompares++;
         $display("FAIL midreset_fresh: R1=%h R2=%h busy=%0d expected %h %h 33", r1, r2, bc, e1, e2);
      end
   endtask

   initial begin
      test_reset();
      test_mul_directed();
      test_div_directed();
      test_random(40, 1'b0);
      test_random(8, 1'b1);
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
